// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/memory_responder_array.sv
// rtl/memory_responder_array.sv - word storage with one sync write and one sync read port
module memory_responder_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the owner's enables move data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency single-request memory responder
module memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept, illegal;
  logic              op_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid;
  logic              enter_done;
  logic              acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] arr_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: begin
        if (MemRead ^ MemWrite) begin
          accept    = 1'b1;
          cnt_nxt   = LOAD;
          state_nxt = (LOAD == '0) ? DONE : WAIT;
        end else if (MemRead && MemWrite) begin
          illegal = 1'b1;
        end
      end
      WAIT: begin
        // Leave on the edge that brings the count down to zero.
        cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the accepting edge is also the access edge, so bypass the latches.
  assign enter_done = (state_nxt == DONE) && (state != DONE) && rst_n;
  assign acc_rd     = (state == IDLE) ? MemRead : op_rd;
  assign acc_addr   = (state == IDLE) ? addr    : addr_q;
  assign acc_wdata  = (state == IDLE) ? wdata   : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      op_rd    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= illegal;
      if (accept) begin
        op_rd   <= MemRead;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enter_done && acc_rd) rd_valid <= 1'b1;
    end
  end

  memory_responder_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (enter_done && !acc_rd),
    .waddr(acc_addr),
    .wdata(acc_wdata),
    .re   (enter_done && acc_rd),
    .raddr(acc_addr),
    .rdata(arr_rdata)
  );

  // Array output only moves on reads, so it already holds between reads.
  assign rdata     = rd_valid ? arr_rdata : '0;
  assign mem_ready = (state == DONE);
  assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder
module tb_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_long;
  logic        MemRead, MemWrite;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        mem_ready, mem_busy, err;

  logic        one = 1'b1, zero = 1'b0;
  logic [7:0]  a_ff = 8'hFF;
  logic [15:0] w_z = 16'h0;
  logic [15:0] rdata1, rdata15;
  logic        ready1, busy1, err1, ready15, busy15, err15;

  always #5 clk = ~clk;

  memory_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .err(err));

  memory_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n_long), .MemRead(one), .MemWrite(zero),
    .addr(a_ff), .wdata(w_z), .rdata(rdata1), .mem_ready(ready1),
    .mem_busy(busy1), .err(err1));

  memory_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n_long), .MemRead(one), .MemWrite(zero),
    .addr(a_ff), .wdata(w_z), .rdata(rdata15), .mem_ready(ready15),
    .mem_busy(busy15), .err(err15));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ready_cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          err_cyc = -1;
  logic [15:0] model [256];
  logic [15:0] last_rd = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("err_pulse", {31'b0, err}, {31'b0, cyc == err_cyc});
      if (mem_ready) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_cycle", cyc, e.ready_cyc);
          check("rdata", {16'b0, rdata}, {16'b0, e.rdata});
        end
      end
    end
  end

  int last1 = -1, idle1 = 0, n1 = 0;
  int last15 = -1, idle15 = 0, n15 = 0;
  always @(negedge clk) begin
    if (rst_n_long) begin
      if (!busy1) idle1++;
      if (ready1) begin
        if (last1 >= 0) begin
          check("period_l1", cyc - last1, 2);
          check("idle_l1", idle1, 1);
          n1++;
        end
        last1 = cyc;
        idle1 = 0;
      end
      if (!busy15) idle15++;
      if (ready15) begin
        if (last15 >= 0) begin
          check("period_l15", cyc - last15, 16);
          check("idle_l15", idle15, 1);
          n15++;
        end
        last15 = cyc;
        idle15 = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (mem_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
    int acc;
    exp_t e;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    acc      = cyc + 1;
    if (rd ^ wr) begin
      if (rd) last_rd = model[a];
      else    model[a] = d;
      e.ready_cyc = acc + LAT - 1;
      e.rdata     = last_rd;
      sb.push_back(e);
    end else if (rd && wr) begin
      err_cyc = acc;
    end
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = ~a;
    wdata    = ~d;
    if (rd && wr) check("illegal_busy", {31'b0, mem_busy}, 32'd0);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; rst_n_long = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; addr = 8'h0; wdata = 16'h0;
    #12;
    check("rst_rdata", {16'b0, rdata}, 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_busy",  {31'b0, mem_busy}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_long = 1'b1;
    do_req(1'b0, 1'b1, 8'h05, 16'h0505);
    do_req(1'b0, 1'b1, 8'h20, 16'h2020);
    do_req(1'b0, 1'b1, 8'h21, 16'h2121);
    do_req(1'b0, 1'b1, 8'h30, 16'h3030);
    do_req(1'b0, 1'b1, 8'h12, 16'hBEEF);
    do_req(1'b1, 1'b0, 8'h12, 16'h0000);
    do_req(1'b1, 1'b1, 8'h05, 16'hDEAD);
    do_req(1'b1, 1'b0, 8'h05, 16'h0000);

    // Write to 0x21 offered only while the read of 0x20 is in WAIT.
    begin
      exp_t e;
      MemRead = 1'b1; addr = 8'h20;
      last_rd = model[8'h20];
      e.ready_cyc = cyc + LAT;
      e.rdata     = last_rd;
      sb.push_back(e);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b1; addr = 8'h21; wdata = 16'h1111;
      @(negedge clk);
      MemWrite = 1'b0; addr = 8'h00; wdata = 16'h0;
      wait_idle();
    end
    do_req(1'b1, 1'b0, 8'h21, 16'h0000);

    // Abort an in-flight write with reset.
    MemWrite = 1'b1; addr = 8'h30; wdata = 16'hAAAA;
    @(negedge clk);
    MemWrite = 1'b0; addr = 8'h00; wdata = 16'h0;
    check("pre_abort_busy", {31'b0, mem_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rdata", {16'b0, rdata}, 32'd0);
    check("abort_ready", {31'b0, mem_ready}, 32'd0);
    check("abort_busy",  {31'b0, mem_busy}, 32'd0);
    check("abort_err",   {31'b0, err}, 32'd0);
    last_rd = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, 8'h30, 16'h0000);
    do_req(1'b0, 1'b1, 8'h12, 16'h1234);
    do_req(1'b1, 1'b0, 8'h12, 16'h0000);
    do_req(1'b0, 1'b1, 8'h00, 16'h0F0F);
    do_req(1'b0, 1'b1, 8'hFE, 16'hF0F0);
    do_req(1'b1, 1'b0, 8'h00, 16'h0000);
    do_req(1'b1, 1'b0, 8'hFE, 16'h0000);

    repeat (60) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("l1_pulses_seen",  {31'b0, n1 >= 10}, 32'd1);
    check("l15_pulses_seen", {31'b0, n15 >= 5}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DATA_W, default 16: width of the data word.
REQ-002 Parameter ADDR_W, default 8: width of the word address; storage depth is 2**ADDR_W words.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: number of cycles from request acceptance to completion.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port MemRead, input, 1: read request from the control unit, level-sampled.
REQ-007 Port MemWrite, input, 1: write request from the control unit, level-sampled.
REQ-008 Port addr, input, ADDR_W: word address of the request.
REQ-009 Port wdata, input, DATA_W: write data.
REQ-010 Port rdata, output, DATA_W: read data, valid while mem_ready=1 after a read, held until the next read completes.
REQ-011 Port mem_ready, output, 1: one-cycle completion pulse.
REQ-012 Port mem_busy, output, 1: high while a request is in flight, meaning state is WAIT or DONE.
REQ-013 Port err, output, 1: one-cycle pulse flagging an illegal request.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 In IDLE, a rising edge with exactly one of MemRead/MemWrite high SHALL accept the request.
  - addr, wdata and the op type are latched.
  - The latency counter is loaded with LATENCY-1.
  - Next state is WAIT, or DONE directly if LATENCY=1.
REQ-016 In WAIT, the counter SHALL decrement on each edge; the FSM enters DONE on the edge where the counter is 0.
REQ-017 The edge that enters DONE SHALL perform the access.
  - Read: loads rdata from the latched address.
  - Write: commits the latched wdata to the latched address.
REQ-018 mem_ready SHALL be 1 exactly during the DONE cycle, which is LATENCY cycles after the accepting edge.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-020 Requests present in WAIT or DONE SHALL be ignored; nothing is queued.
  - A request still held high on return to IDLE is accepted as a new request.
REQ-021 MemRead=1 and MemWrite=1 together in IDLE SHALL NOT be accepted.
  - err pulses high for the next cycle.
  - The FSM stays in IDLE and storage is unchanged.
REQ-022 Inputs addr and wdata changing after acceptance SHALL NOT affect the in-flight access.
REQ-023 A read of an address written by the immediately preceding completed write SHALL return the new data.
REQ-024 An address wrap-around SHALL NOT exist; every addr value is a valid word.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force the following, regardless of clk:
  - state to IDLE and the counter to 0;
  - rdata to 0;
  - mem_ready, mem_busy and err to 0.
REQ-026 Reset mid-operation SHALL abort the in-flight request; a pending write is discarded.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 The package mem_pkg SHALL hold:
  - the state encoding (IDLE, WAIT, DONE);
  - the default DATA_W and ADDR_W constants;
  - the LATENCY default and the counter width (4 bits).
REQ-030 Storage SHALL be a single sub-module, memory_responder_array.
  - One synchronous write port and one synchronous read port.
  - No reset on the array.
REQ-031 The FSM, counter and request latches SHALL reside in memory_responder.

Verification (LATENCY=2 unless stated)
REQ-032 Write then read: write 0xBEEF to addr 0x12, then read 0x12.
  - mem_ready pulses 2 cycles after each accept.
  - rdata=0xBEEF during the read's mem_ready.
REQ-033 Illegal request: MemRead=MemWrite=1 at addr 0x05 in IDLE.
  - err=1 for one cycle, mem_busy stays 0.
  - A subsequent read of 0x05 returns its prior value.
REQ-034 Busy ignore: accept a read of 0x20, then assert a write of 0x1111 to 0x21 during WAIT only.
  - Address 0x21 is unchanged.
  - Exactly one mem_ready pulse occurs.
REQ-035 Reset mid-operation: accept a write of 0xAAAA to 0x30, then pull rst_n low during WAIT.
  - All outputs go to 0 asynchronously.
  - A read of 0x30 after reset returns the pre-write value.
REQ-036 LATENCY=1 and LATENCY=15 builds: held MemRead=1 at addr 0xFF.
  - mem_ready every 2 and every 16 cycles respectively.
  - mem_busy is low only in the IDLE cycles between requests.
